// File: rtl/current_sense_readout.sv
// TLI4970 SPI readout: periodic 16-bit receive-only frames, parity check, signed current word.
// Define CURRENT_FILTER_EN to pass accepted samples through a first-order IIR before `current`.
module current_sense_readout #(
    parameter int CLK_DIV        = 16,
    parameter int SAMPLE_PERIOD  = 64000,
    parameter int CS_SETUP       = 32,
    parameter int CURRENT_OFFSET = 4096
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               CS_MISO,
    output logic               CS,
    output logic               CS_CLK,
    output logic signed [12:0] current,
    output logic               current_valid,
    output logic               overcurrent,
    output logic               status_frame,
    output logic               parity_error,
    output logic [7:0]         error_count
);

    localparam int TW   = $clog2(SAMPLE_PERIOD + 1);
    localparam int CMAX = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, CHECK} state_e;

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               req_q, req_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         bit_q, bit_d;
    logic [15:0]        shreg_q, shreg_d;
    logic               miso_meta_q, miso_sync_q;
    logic               cs_q, cs_d;
    logic               sck_q, sck_d;
    logic signed [12:0] cur_q, cur_d;
    logic               valid_q, valid_d;
    logic               oc_q, oc_d;
    logic               status_q, status_d;
    logic               perr_q, perr_d;
    logic [7:0]         err_q, err_d;
    logic signed [12:0] sample;
    logic               req_set;

    assign sample = $signed(shreg_q[12:0] - 13'(CURRENT_OFFSET));

`ifdef CURRENT_FILTER_EN
    logic signed [16:0] acc_q, acc_d, acc_nx;
    logic signed [17:0] diff;
    assign diff   = 18'($signed({sample, 4'b0000})) - 18'(acc_q);
    assign acc_nx = acc_q + 17'(diff >>> 2);
`endif

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TW'(1);
        req_d    = req_q;
        req_set  = 1'b0;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        cs_d     = cs_q;
        sck_d    = sck_q;
        cur_d    = cur_q;
        valid_d  = 1'b0;
        oc_d     = oc_q;
        status_d = 1'b0;
        perr_d   = perr_q;
        err_d    = err_q;
`ifdef CURRENT_FILTER_EN
        acc_d    = acc_q;
`endif
        if (timer_q == TW'(SAMPLE_PERIOD - 1)) begin
            timer_d = '0;
            req_set = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                cs_d  = 1'b1;
                sck_d = 1'b0;
                if (req_q) begin
                    state_d = SETUP;
                    cs_d    = 1'b0;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == CW'(CS_SETUP - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        // Capture on the same edge that raises SCK.
                        sck_d   = 1'b1;
                        shreg_d = {shreg_q[14:0], miso_sync_q};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 4'd15) state_d = HOLD;
                        else bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cs_d    = 1'b1;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (^shreg_q) begin
                    perr_d = 1'b1;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end else begin
                    perr_d = 1'b0;
                    if (shreg_q[15]) begin
                        status_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        oc_d    = shreg_q[13];
`ifdef CURRENT_FILTER_EN
                        acc_d   = acc_nx;
                        cur_d   = acc_nx[16:4];
`else
                        cur_d   = sample;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (req_set) req_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            req_q       <= 1'b0;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
            cs_q        <= 1'b1;
            sck_q       <= 1'b0;
            cur_q       <= '0;
            valid_q     <= 1'b0;
            oc_q        <= 1'b0;
            status_q    <= 1'b0;
            perr_q      <= 1'b0;
            err_q       <= '0;
`ifdef CURRENT_FILTER_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            miso_meta_q <= CS_MISO;
            miso_sync_q <= miso_meta_q;
            cs_q        <= cs_d;
            sck_q       <= sck_d;
            cur_q       <= cur_d;
            valid_q     <= valid_d;
            oc_q        <= oc_d;
            status_q    <= status_d;
            perr_q      <= perr_d;
            err_q       <= err_d;
`ifdef CURRENT_FILTER_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign CS            = cs_q;
    assign CS_CLK        = sck_q;
    assign current       = cur_q;
    assign current_valid = valid_q;
    assign overcurrent   = oc_q;
    assign status_frame  = status_q;
    assign parity_error  = perr_q;
    assign error_count   = err_q;

endmodule

// File: tb/tb_current_sense_readout.sv
// Bench for current_sense_readout: sensor model on the SPI pins, table + random frames
// against a frame-level reference model, reset mid-frame, and a default-timing waveform check.
module tb_current_sense_readout;

    localparam int CD  = 4;
    localparam int SP  = 200;
    localparam int CSS = 8;

    logic               CLK = 1'b0;
    logic               reset = 1'b1;
    logic               CS_MISO = 1'b0;
    logic               CS, CS_CLK;
    logic signed [12:0] current;
    logic               current_valid, overcurrent, status_frame, parity_error;
    logic [7:0]         error_count;

    logic               w_miso = 1'b0;
    logic               w_cs, w_sck, w_valid, w_oc, w_status, w_perr;
    logic signed [12:0] w_current;
    logic [7:0]         w_err;

    always #5 CLK = ~CLK;

    current_sense_readout #(
        .CLK_DIV(CD), .SAMPLE_PERIOD(SP), .CS_SETUP(CSS), .CURRENT_OFFSET(4096)
    ) u_dut (
        .CLK(CLK), .reset(reset), .CS_MISO(CS_MISO), .CS(CS), .CS_CLK(CS_CLK),
        .current(current), .current_valid(current_valid), .overcurrent(overcurrent),
        .status_frame(status_frame), .parity_error(parity_error), .error_count(error_count)
    );

    current_sense_readout #(
        .CLK_DIV(16), .SAMPLE_PERIOD(1000), .CS_SETUP(32), .CURRENT_OFFSET(4096)
    ) u_wave (
        .CLK(CLK), .reset(reset), .CS_MISO(w_miso), .CS(w_cs), .CS_CLK(w_sck),
        .current(w_current), .current_valid(w_valid), .overcurrent(w_oc),
        .status_frame(w_status), .parity_error(w_perr), .error_count(w_err)
    );

    // Sensor: first bit valid when CS falls, next bit after each SCK falling edge.
    logic [15:0] frame_v = 16'h0000;
    logic [15:0] sh = 16'h0000;
    int          idx = 0;

    always @(negedge CS) begin
        sh      <= frame_v;
        idx     <= 15;
        CS_MISO <= frame_v[15];
    end

    always @(negedge CS_CLK) begin
        if (CS === 1'b0 && idx > 0) begin
            idx     <= idx - 1;
            CS_MISO <= sh[idx-1];
        end
    end

    int nv = 0, ns = 0;
    always @(negedge CLK) begin
        if (current_valid === 1'b1) nv <= nv + 1;
        if (status_frame === 1'b1) ns <= ns + 1;
    end

    int w_low = 0, w_rises = 0, w_period = 0, w_cyc = 0, w_last = -1;
    bit w_done = 1'b0, w_prev_sck = 1'b0, w_prev_cs = 1'b1;
    always @(negedge CLK) begin
        w_cyc      <= w_cyc + 1;
        w_prev_sck <= (w_sck === 1'b1);
        w_prev_cs  <= (w_cs !== 1'b0);
        if (!w_done) begin
            if (w_cs === 1'b0) w_low <= w_low + 1;
            if (w_sck === 1'b1 && !w_prev_sck) begin
                w_rises <= w_rises + 1;
                if (w_last >= 0) w_period <= w_cyc - w_last;
                w_last <= w_cyc;
            end
            if (w_cs === 1'b1 && !w_prev_cs && w_low > 0) w_done <= 1'b1;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model at frame level.
    int m_cur = 0, m_oc = 0, m_perr = 0, m_err = 0, m_v = 0, m_s = 0, m_acc = 0;

    function automatic void model_reset();
        m_cur = 0; m_oc = 0; m_perr = 0; m_err = 0; m_v = 0; m_s = 0; m_acc = 0;
    endfunction

    function automatic void model_apply(input logic [15:0] f);
        int samp;
        m_v = 0;
        m_s = 0;
        if ($countones(f) % 2 != 0) begin
            m_perr = 1;
            if (m_err < 255) m_err = m_err + 1;
        end else begin
            m_perr = 0;
            if (f[15]) begin
                m_s = 1;
            end else begin
                samp = int'(f[12:0]) - 4096;
                m_oc = int'(f[13]);
                m_v  = 1;
`ifdef CURRENT_FILTER_EN
                m_acc = m_acc + ((samp * 16 - m_acc) >>> 2);
                m_cur = m_acc >>> 4;
`else
                m_cur = samp;
`endif
            end
        end
    endfunction

    task automatic wait_frame(output bit ok);
        bit seen_low;
        ok = 1'b0;
        seen_low = 1'b0;
        for (int n = 0; n < 4 * SP; n++) begin
            @(negedge CLK);
            if (CS === 1'b0) seen_low = 1'b1;
            else if (seen_low) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    int dv, ds;

    task automatic do_frame(input logic [15:0] f);
        bit ok;
        int nv0, ns0;
        frame_v = f;
        nv0 = nv;
        ns0 = ns;
        wait_frame(ok);
        chk("frame_done", int'(ok), 1);
        model_apply(f);
        @(negedge CLK);
        chk("current_valid", int'(current_valid), m_v);
        chk("status_frame", int'(status_frame), m_s);
        chk("current", int'(current), m_cur);
        chk("overcurrent", int'(overcurrent), m_oc);
        chk("parity_error", int'(parity_error), m_perr);
        chk("error_count", int'(error_count), m_err);
        @(negedge CLK);
        dv = nv - nv0;
        ds = ns - ns0;
        chk("valid_pulses", dv, m_v);
        chk("status_pulses", ds, m_s);
    endtask

    typedef struct {
        logic [15:0] frame;
        int          v;
        int          s;
        int          cur;
        int          oc;
        int          perr;
        int          err;
    } vec_t;

    vec_t tab[9];

    initial begin
        logic [15:0] f;
        int          nv0, ns0, rises, n;
        bit          prev;

        tab[0] = '{16'h5000, 1, 0,     0, 0, 0, 0};
        tab[1] = '{16'h3FFF, 1, 0,  4095, 1, 0, 0};
        tab[2] = '{16'h3FFE, 0, 0,  4095, 1, 1, 1};
        tab[3] = '{16'h8001, 0, 1,  4095, 1, 0, 1};
        tab[4] = '{16'h0000, 1, 0, -4096, 0, 0, 1};
        tab[5] = '{16'h4000, 0, 0, -4096, 0, 1, 2};
        tab[6] = '{16'h2001, 1, 0, -4095, 1, 0, 2};
        tab[7] = '{16'hC000, 0, 1, -4095, 1, 0, 2};
        tab[8] = '{16'h5FFF, 1, 0,  4095, 0, 0, 2};

        reset = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_cs", int'(CS), 1);
        chk("rst_cs_clk", int'(CS_CLK), 0);
        chk("rst_current", int'(current), 0);
        chk("rst_valid", int'(current_valid), 0);
        chk("rst_oc", int'(overcurrent), 0);
        chk("rst_status", int'(status_frame), 0);
        chk("rst_perr", int'(parity_error), 0);
        chk("rst_err", int'(error_count), 0);
        reset = 1'b0;
        model_reset();

`ifndef CURRENT_FILTER_EN
        for (int i = 0; i < 9; i++) begin
            do_frame(tab[i].frame);
            chk("tab_valid", dv, tab[i].v);
            chk("tab_status", ds, tab[i].s);
            chk("tab_current", int'(current), tab[i].cur);
            chk("tab_oc", int'(overcurrent), tab[i].oc);
            chk("tab_perr", int'(parity_error), tab[i].perr);
            chk("tab_err", int'(error_count), tab[i].err);
        end
`else
        for (int i = 0; i < 6; i++) begin
            do_frame(16'h5064);
        end
`endif

        for (int i = 0; i < 20; i++) begin
            f = 16'($urandom);
            if ($urandom_range(0, 2) != 0) f[14] = ^{f[15], f[13:0]};
            do_frame(f);
        end

        for (int i = 0; i < 256; i++) begin
            f = 16'($urandom);
            f[14] = ~(^{f[15], f[13:0]});
            do_frame(f);
        end
        chk("err_saturated", int'(error_count), 255);

        // Reset in the high phase of bit 7.
        frame_v = 16'h5000;
        nv0 = nv;
        ns0 = ns;
        n = 0;
        while (CS !== 1'b0 && n < 2 * SP) begin
            @(negedge CLK);
            n++;
        end
        chk("cs_fall_seen", int'(CS === 1'b0), 1);
        rises = 0;
        prev = 1'b0;
        for (int k = 0; k < 400 && rises < 8; k++) begin
            @(negedge CLK);
            if (CS_CLK === 1'b1 && !prev) rises++;
            prev = (CS_CLK === 1'b1);
        end
        chk("reached_bit7", rises, 8);
        reset = 1'b1;
        @(negedge CLK);
        chk("mid_rst_cs", int'(CS), 1);
        chk("mid_rst_cs_clk", int'(CS_CLK), 0);
        chk("mid_rst_current", int'(current), 0);
        chk("mid_rst_err", int'(error_count), 0);
        chk("mid_rst_perr", int'(parity_error), 0);
        reset = 1'b0;
        model_reset();
        n = 0;
        while (CS !== 1'b0 && n < SP + 20) begin
            @(negedge CLK);
            n++;
        end
        chk("restart_delay", n, SP + 1);
        chk("mid_rst_no_valid", nv - nv0, 0);
        chk("mid_rst_no_status", ns - ns0, 0);
        do_frame(16'h5000);

        chk("wave_done", int'(w_done), 1);
        chk("wave_cs_low", w_low, 560);
        chk("wave_sck_rises", w_rises, 16);
        chk("wave_sck_period", w_period, 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
